// File: rtl/ps_loop_ctrl.sv
// rtl/ps_loop_ctrl.sv - DO-UNTIL hardware loop stack and end-of-loop redirect control
// Optional: LP_ERR_STICKY_EN makes lp_ovf/lp_udf hold until reset.
module ps_loop_ctrl #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 16,
  parameter int DEPTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lp_push,
  input  logic [PC_W-1:0]  lp_start_pc,
  input  logic [PC_W-1:0]  lp_end_pc,
  input  logic [CNT_W-1:0] lp_cnt,
  input  logic             lp_mode,
  input  logic [4:0]       lp_cnd,
  input  logic             lp_pop,
  input  logic             fetch_vld,
  input  logic [PC_W-1:0]  fetch_pc,
  input  logic             cnd_stat,
  output logic             cnd_en,
  output logic [4:0]       op_cnd,
  output logic             lp_jmp,
  output logic [PC_W-1:0]  lp_jmp_pc,
  output logic             lp_active,
  output logic [2:0]       lp_depth,
  output logic [CNT_W-1:0] lp_curcnt,
  output logic             lp_ovf,
  output logic             lp_udf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0]  stk_start [DEPTH];
  logic [PC_W-1:0]  stk_end   [DEPTH];
  logic [CNT_W-1:0] stk_cnt   [DEPTH];
  logic             stk_mode  [DEPTH];
  logic [4:0]       stk_cnd   [DEPTH];

  logic [1:0]      state_q;
  logic [2:0]      depth_q;
  logic [PC_W-1:0] jmp_pc_q;
  logic            ovf_q;
  logic            udf_q;

  logic [2:0]       top_idx;
  logic             end_match;
  logic [2:0]       depth_n;
  logic             jmp_n;
  logic [PC_W-1:0]  jmp_pc_n;
  logic             dec_top;
  logic             wr_en;
  logic [2:0]       wr_idx;
  logic             ovf_evt;
  logic             udf_evt;

  assign top_idx   = (depth_q == 3'd0) ? 3'd0 : depth_q - 3'd1;
  assign lp_active = (depth_q != 3'd0);
  assign end_match = fetch_vld && lp_active && (fetch_pc == stk_end[top_idx]);

  // The decoder is queried on every condition-loop end match, even if lp_pop overrides it.
  assign cnd_en = end_match && !stk_mode[top_idx];
  assign op_cnd = cnd_en ? stk_cnd[top_idx] : 5'b0;

  always_comb begin
    depth_n  = depth_q;
    jmp_n    = 1'b0;
    jmp_pc_n = '0;
    dec_top  = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = 3'd0;
    ovf_evt  = 1'b0;
    udf_evt  = 1'b0;

    if (lp_pop) begin
      if (depth_q == 3'd0) udf_evt = 1'b1;
      else                 depth_n = depth_q - 3'd1;
    end else if (end_match) begin
      if (stk_mode[top_idx]) begin
        if (stk_cnt[top_idx] == CNT_ONE) begin
          depth_n = depth_q - 3'd1;
        end else begin
          dec_top  = 1'b1;
          jmp_n    = 1'b1;
          jmp_pc_n = stk_start[top_idx];
        end
      end else if (cnd_stat) begin
        depth_n = depth_q - 3'd1;
      end else begin
        jmp_n    = 1'b1;
        jmp_pc_n = stk_start[top_idx];
      end
    end

    // Push lands on the stack as already adjusted by the pop/end-match decision above.
    if (lp_push) begin
      if (lp_mode && (lp_cnt == '0)) begin
        jmp_n    = 1'b1;
        jmp_pc_n = lp_end_pc + PC_ONE;
      end else if (depth_n == 3'(DEPTH)) begin
        ovf_evt = 1'b1;
      end else begin
        wr_en   = 1'b1;
        wr_idx  = depth_n;
        depth_n = depth_n + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      depth_q  <= 3'd0;
      jmp_pc_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_start[i] <= '0;
        stk_end[i]   <= '0;
        stk_cnt[i]   <= '0;
        stk_mode[i]  <= 1'b0;
        stk_cnd[i]   <= 5'b0;
      end
    end else begin
      if (jmp_n)                  state_q <= S_REDIR;
      else if (depth_n != 3'd0)   state_q <= S_RUN;
      else                        state_q <= S_IDLE;
      depth_q  <= depth_n;
      jmp_pc_q <= jmp_pc_n;
`ifdef LP_ERR_STICKY_EN
      ovf_q <= ovf_q | ovf_evt;
      udf_q <= udf_q | udf_evt;
`else
      ovf_q <= ovf_evt;
      udf_q <= udf_evt;
`endif
      if (dec_top) stk_cnt[top_idx] <= stk_cnt[top_idx] - CNT_ONE;
      if (wr_en) begin
        stk_start[wr_idx] <= lp_start_pc;
        stk_end[wr_idx]   <= lp_end_pc;
        stk_cnt[wr_idx]   <= lp_cnt;
        stk_mode[wr_idx]  <= lp_mode;
        stk_cnd[wr_idx]   <= lp_cnd;
      end
    end
  end

  assign lp_jmp    = (state_q == S_REDIR);
  assign lp_jmp_pc = jmp_pc_q;
  assign lp_depth  = depth_q;
  assign lp_curcnt = (lp_active && stk_mode[top_idx]) ? stk_cnt[top_idx] : '0;
  assign lp_ovf    = ovf_q;
  assign lp_udf    = udf_q;

endmodule

// File: tb/tb_ps_loop_ctrl.sv
// tb/tb_ps_loop_ctrl.sv - directed and randomized check of ps_loop_ctrl against a queue model
module tb_ps_loop_ctrl;
  localparam int PC_W  = 16;
  localparam int CNT_W = 16;
  localparam int DEPTH = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, lp_push, lp_mode, lp_pop, fetch_vld, cnd_stat;
  logic [PC_W-1:0]  lp_start_pc, lp_end_pc, fetch_pc;
  logic [CNT_W-1:0] lp_cnt;
  logic [4:0]       lp_cnd;
  logic             cnd_en, lp_jmp, lp_active, lp_ovf, lp_udf;
  logic [4:0]       op_cnd;
  logic [PC_W-1:0]  lp_jmp_pc;
  logic [2:0]       lp_depth;
  logic [CNT_W-1:0] lp_curcnt;

  ps_loop_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .lp_push(lp_push), .lp_start_pc(lp_start_pc),
    .lp_end_pc(lp_end_pc), .lp_cnt(lp_cnt), .lp_mode(lp_mode), .lp_cnd(lp_cnd),
    .lp_pop(lp_pop), .fetch_vld(fetch_vld), .fetch_pc(fetch_pc), .cnd_stat(cnd_stat),
    .cnd_en(cnd_en), .op_cnd(op_cnd), .lp_jmp(lp_jmp), .lp_jmp_pc(lp_jmp_pc),
    .lp_active(lp_active), .lp_depth(lp_depth), .lp_curcnt(lp_curcnt),
    .lp_ovf(lp_ovf), .lp_udf(lp_udf)
  );

  typedef struct packed {
    logic [15:0] s;
    logic [15:0] e;
    logic [15:0] c;
    logic        m;
    logic [4:0]  k;
  } ent_t;

  ent_t        q[$];
  logic        m_jmp, m_ovf, m_udf;
  logic [15:0] m_jpc;
  int          checks = 0;
  int          failures = 0;
  int          inner_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Compare all outputs to the model for this cycle, then advance the model across the edge.
  task automatic step();
    ent_t t;
    logic match, nj, ovf_e, udf_e;
    logic [15:0] npc;
    #1;
    t = (q.size() > 0) ? q[$] : '0;
    match = fetch_vld && (q.size() > 0) && (fetch_pc == t.e);
    chk("cnd_en", {31'b0, cnd_en}, {31'b0, match && !t.m});
    chk("op_cnd", {27'b0, op_cnd}, {27'b0, (match && !t.m) ? t.k : 5'b0});
    chk("lp_jmp", {31'b0, lp_jmp}, {31'b0, m_jmp});
    chk("lp_jmp_pc", {16'b0, lp_jmp_pc}, {16'b0, m_jpc});
    chk("lp_active", {31'b0, lp_active}, {31'b0, q.size() > 0});
    chk("lp_depth", {29'b0, lp_depth}, q.size());
    chk("lp_curcnt", {16'b0, lp_curcnt}, {16'b0, (q.size() > 0 && t.m) ? t.c : 16'h0});
    chk("lp_ovf", {31'b0, lp_ovf}, {31'b0, m_ovf});
    chk("lp_udf", {31'b0, lp_udf}, {31'b0, m_udf});

    nj = 1'b0; npc = 16'h0; ovf_e = 1'b0; udf_e = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_jmp = 1'b0; m_jpc = 16'h0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (lp_pop) begin
        if (q.size() == 0) udf_e = 1'b1;
        else void'(q.pop_back());
      end else if (match) begin
        if (t.m ? (t.c == 16'd1) : cnd_stat) begin
          void'(q.pop_back());
        end else begin
          if (t.m) begin
            t.c = t.c - 16'd1;
            q[q.size()-1] = t;
          end
          nj = 1'b1; npc = t.s;
        end
      end
      if (lp_push) begin
        if (lp_mode && lp_cnt == 16'd0) begin
          nj = 1'b1; npc = lp_end_pc + 16'd1;
        end else if (q.size() == DEPTH) begin
          ovf_e = 1'b1;
        end else begin
          q.push_back({lp_start_pc, lp_end_pc, lp_cnt, lp_mode, lp_cnd});
        end
      end
      m_jmp = nj; m_jpc = npc;
`ifdef LP_ERR_STICKY_EN
      m_ovf = m_ovf | ovf_e; m_udf = m_udf | udf_e;
`else
      m_ovf = ovf_e; m_udf = udf_e;
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; lp_push = 1'b0; lp_pop = 1'b0; fetch_vld = 1'b0; cnd_stat = 1'b0;
    lp_start_pc = '0; lp_end_pc = '0; lp_cnt = '0; lp_mode = 1'b0; lp_cnd = 5'b0;
    fetch_pc = '0;
  endtask

  task automatic do_push(input logic [15:0] s, input logic [15:0] e, input logic [15:0] c,
                         input logic m, input logic [4:0] k);
    lp_push = 1'b1; lp_start_pc = s; lp_end_pc = e; lp_cnt = c; lp_mode = m; lp_cnd = k;
    step();
    idle_inputs();
  endtask

  task automatic do_fetch(input logic [15:0] pc, input logic stat);
    fetch_vld = 1'b1; fetch_pc = pc; cnd_stat = stat;
    step();
    idle_inputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    q.delete();
    m_jmp = 1'b0; m_jpc = 16'h0; m_ovf = 1'b0; m_udf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    chk("rst_depth", {29'b0, lp_depth}, 32'd0);
    chk("rst_jmp", {31'b0, lp_jmp}, 32'd0);

    // Counter loop, three passes
    do_push(16'h10, 16'h13, 16'd3, 1'b1, 5'd0);
    chk("t1_curcnt0", {16'b0, lp_curcnt}, 32'd3);
    for (int p = 0; p < 3; p++) begin
      for (int pc = 16'h10; pc <= 16'h13; pc++) do_fetch(16'(pc), 1'b0);
      if (p < 2) begin
        chk("t1_jmp", {31'b0, lp_jmp}, 32'd1);
        chk("t1_jmp_pc", {16'b0, lp_jmp_pc}, 32'h10);
        chk("t1_curcnt", {16'b0, lp_curcnt}, 32'(2 - p));
      end
    end
    chk("t1_fall_jmp", {31'b0, lp_jmp}, 32'd0);
    chk("t1_depth", {29'b0, lp_depth}, 32'd0);

    // Condition loop, stat 0,0,1
    do_push(16'h40, 16'h42, 16'd0, 1'b0, 5'b00000);
    for (int p = 0; p < 3; p++) begin
      do_fetch(16'h40, 1'b0);
      do_fetch(16'h41, 1'b0);
      fetch_vld = 1'b1; fetch_pc = 16'h42; cnd_stat = (p == 2);
      #1;
      chk("t2_cnd_en", {31'b0, cnd_en}, 32'd1);
      chk("t2_op_cnd", {27'b0, op_cnd}, 32'd0);
      step();
      idle_inputs();
      chk("t2_jmp", {31'b0, lp_jmp}, (p < 2) ? 32'd1 : 32'd0);
    end
    chk("t2_depth", {29'b0, lp_depth}, 32'd0);

    // Zero-count loop skips with PC wrap
    do_push(16'h0, 16'hFFFF, 16'd0, 1'b1, 5'd0);
    chk("t3_jmp", {31'b0, lp_jmp}, 32'd1);
    chk("t3_jmp_pc", {16'b0, lp_jmp_pc}, 32'h0);
    chk("t3_depth", {29'b0, lp_depth}, 32'd0);

    // Nested loops sharing an end address
    inner_cnt = 0;
    do_push(16'h18, 16'h20, 16'd2, 1'b1, 5'd0);
    for (int o = 0; o < 2; o++) begin
      for (int pc = 16'h18; pc <= 16'h1B; pc++) do_fetch(16'(pc), 1'b0);
      do_push(16'h1C, 16'h20, 16'd2, 1'b1, 5'd0);
      for (int p = 0; p < 2; p++) begin
        for (int pc = 16'h1C; pc <= 16'h20; pc++) begin
          if (pc == 16'h20 && q.size() == 2) inner_cnt++;
          do_fetch(16'(pc), 1'b0);
        end
      end
      do_fetch(16'h20, 1'b0);
      chk("t4_outer_jmp", {31'b0, lp_jmp}, (o == 0) ? 32'd1 : 32'd0);
    end
    chk("t4_inner_passes", inner_cnt, 32'd4);
    chk("t4_depth", {29'b0, lp_depth}, 32'd0);

    // Overflow and underflow
    for (int i = 0; i < 7; i++) do_push(16'h100, 16'(16'h200 + i), 16'd1, 1'b0, 5'(i));
    chk("t5_depth_full", {29'b0, lp_depth}, 32'd6);
    chk("t5_ovf", {31'b0, lp_ovf}, 32'd1);
    step();
`ifdef LP_ERR_STICKY_EN
    chk("t5_ovf_hold", {31'b0, lp_ovf}, 32'd1);
`else
    chk("t5_ovf_hold", {31'b0, lp_ovf}, 32'd0);
`endif
    for (int i = 0; i < 7; i++) begin
      lp_pop = 1'b1;
      step();
      idle_inputs();
    end
    chk("t5_udf", {31'b0, lp_udf}, 32'd1);
    chk("t5_depth_empty", {29'b0, lp_depth}, 32'd0);

    // Reset mid-run
    do_reset();
    for (int i = 0; i < 3; i++) do_push(16'h30, 16'h34, 16'd5, 1'b1, 5'd0);
    do_fetch(16'h34, 1'b0);
    do_reset();
    chk("t6_depth", {29'b0, lp_depth}, 32'd0);
    chk("t6_jmp", {31'b0, lp_jmp}, 32'd0);
    do_fetch(16'h34, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n       = ($urandom_range(0, 299) != 0);
      lp_push     = ($urandom_range(0, 5) == 0);
      lp_pop      = ($urandom_range(0, 11) == 0);
      lp_mode     = $urandom_range(0, 1);
      lp_cnt      = 16'($urandom_range(0, 3));
      lp_cnd      = 5'($urandom);
      lp_start_pc = 16'($urandom_range(0, 7));
      lp_end_pc   = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 7));
      fetch_vld   = ($urandom_range(0, 3) != 0);
      fetch_pc    = 16'($urandom_range(0, 7));
      cnd_stat    = $urandom_range(0, 1);
      step();
    end
    idle_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
